// File: rtl/cos_unit_sched_if.sv
// -----------------------------------------------------------------------------
// cos_unit_sched_if
// Bundle between the expansion-branch requesters / shared cosine datapath and
// the cos_unit_sched scheduler.
//   req         : per-requester level request (requesters -> scheduler)
//   gnt         : one-hot grant pulse (scheduler -> requesters)
//   done        : one-hot result-return pulse (scheduler -> requesters)
//   result      : returned cosine value, valid while done != 0
//   pending     : per-requester outstanding-operation flag
//   sel         : 4:1 operand mux select (scheduler -> datapath)
//   unit_issue  : unit samples the mux output this cycle
//   unit_en     : unit stall enable
//   unit_result : cosine unit output (datapath -> scheduler)
// Modports: master = requester/datapath side, slave = scheduler.
// -----------------------------------------------------------------------------
interface cos_unit_sched_if #(
    parameter int W = 16
);
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [W-1:0] result;
    logic [3:0]   pending;
    logic [1:0]   sel;
    logic         unit_issue;
    logic         unit_en;
    logic [W-1:0] unit_result;

    modport master (
        output req,
        output unit_result,
        input  gnt,
        input  done,
        input  result,
        input  pending,
        input  sel,
        input  unit_issue,
        input  unit_en
    );

    modport slave (
        input  req,
        input  unit_result,
        output gnt,
        output done,
        output result,
        output pending,
        output sel,
        output unit_issue,
        output unit_en
    );
endinterface

// File: rtl/cos_unit_sched.sv
// -----------------------------------------------------------------------------
// cos_unit_sched
// Round-robin scheduler sharing one fixed-latency cosine evaluation unit among
// four expansion-branch requesters. Each grant steers the external operand mux
// (sel) and issues the unit; the requester ID rides a LAT-deep tag pipe that
// advances in lock-step with the unit, and the unit output is handed back to
// its owner with a one-hot done pulse.
//
// Parameters
//   W   : result data width (must match the interface W)
//   LAT : unit latency from issue sample to unit_result valid (LAT >= 1)
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   en  : global advance; 0 freezes scheduler, tag pipe and (via unit_en) unit
//   bus : cos_unit_sched_if.slave (req/gnt/done/result/pending, unit side)
//
// Timing (LAT=3): req sampled at edge E -> gnt/unit_issue in cycle E+1 ->
// done/result in cycle E+LAT+2. At most one outstanding op per requester.
// -----------------------------------------------------------------------------
module cos_unit_sched #(
    parameter int W   = 16,
    parameter int LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    cos_unit_sched_if.slave        bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   ptr_q;
    logic [3:0]   pending_q;
    logic [3:0]   gnt_q;
    logic [1:0]   sel_q;
    logic         issue_q;
    logic [3:0]   done_q;
    logic [W-1:0] result_q;

    // Tag pipe: valid bits and requester IDs, one stage per unit cycle.
    logic [LAT-1:0] tag_valid_q;
    logic [1:0]     tag_id_q [LAT];

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [3:0] eligible;
    logic       pick_valid;
    logic [1:0] pick_id;
    logic [3:0] gnt_mask;
    logic       ret_valid;
    logic [1:0] ret_id;
    logic [3:0] ret_mask;
    logic [3:0] pending_next;

    // Round-robin pick: scan ptr, ptr+1, ... and take the first eligible.
    // The scan runs from the farthest offset down so the nearest hit is the
    // one left standing.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise a path that skips an assignment infers a latch.
        eligible   = bus.req & ~pending_q;
        pick_valid = 1'b0;
        pick_id    = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            logic [1:0] cand;
            cand = ptr_q + 2'(i);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Return path: the tail tag lines up with unit_result this cycle.
    always_comb begin
        gnt_mask     = pick_valid ? (4'b0001 << pick_id) : 4'b0000;
        ret_valid    = en & tag_valid_q[LAT-1];
        ret_id       = tag_id_q[LAT-1];
        ret_mask     = ret_valid ? (4'b0001 << ret_id) : 4'b0000;
        // A grant and a return never name the same requester, because a
        // pending requester is never eligible; both can apply at one edge.
        pending_next = (pending_q | gnt_mask) & ~ret_mask;
    end

    // ------------------------------------------------------------------
    // Scheduler registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here samples pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q     <= 2'd0;
            pending_q <= 4'b0000;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            issue_q   <= 1'b0;
            done_q    <= 4'b0000;
            result_q  <= '0;
        end else if (en) begin
            gnt_q     <= gnt_mask;
            issue_q   <= pick_valid;
            pending_q <= pending_next;
            if (pick_valid) begin
                sel_q <= pick_id;
                ptr_q <= pick_id + 2'd1;
            end
            done_q <= ret_mask;
            if (ret_valid) begin
                result_q <= bus.unit_result;
            end
        end else begin
            // Frozen: pulses drop, everything else holds. issue_q and sel_q
            // hold so an issue the stalled unit has not yet sampled is still
            // presented (and captured by the tag pipe) on resume.
            gnt_q  <= 4'b0000;
            done_q <= 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
        end else if (en) begin
            tag_valid_q[0] <= issue_q;
            for (int i = 1; i < LAT; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
            end
        end
    end

    // NOTE: the ID stages carry no reset; they are only consumed when the
    // matching valid bit is set, and that bit is cleared by reset.
    always_ff @(posedge clk) begin
        if (en) begin
            tag_id_q[0] <= sel_q;
            for (int i = 1; i < LAT; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.unit_issue = issue_q;
    assign bus.unit_en    = en;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.pending    = pending_q;

endmodule
